// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//
// Purpose:
//   Bundles the three buses that meet at the data-memory arbiter: the CPU
//   M-stage access port, the DMA/debug access port and the single-ported data
//   memory. Clock and reset are not carried here.
//
// Modports:
//   slave  - the arbiter. It receives requests from the CPU and DMA, and the
//            memory read data. It drives the grant/enable, the memory command
//            and the read returns.
//   master - the surroundings (CPU pipeline, DMA engine, memory macro). This
//            is the mirror image of slave.
//
// Signal summary:
//   cpu_en_in          global CPU enable from the top level
//   cpu_en             enable to the CPU pipeline (low = frozen)
//   cpu_mem_write_en   CPU byte write enables, bit 3 = address byte 0
//   cpu_mem_read_en    CPU load request
//   cpu_mem_addr       CPU byte address
//   cpu_mem_write_data CPU store data
//   cpu_mem_read_data  load data presented to the CPU M stage
//   dma_req            DMA request, held until granted
//   dma_we             DMA byte write enables, 4'b0000 = read
//   dma_addr           DMA byte address
//   dma_wdata          DMA write data
//   dma_gnt            DMA access accepted this cycle
//   dma_rvalid         DMA read data valid
//   dma_rdata          DMA read data
//   mem_write_en       byte write enables to memory
//   mem_read_en        read enable to memory
//   mem_addr           byte address to memory
//   mem_write_data     write data to memory
//   mem_read_data      read data from memory, one cycle after mem_read_en
// -----------------------------------------------------------------------------
interface dmem_arbiter_if;

  // CPU M-stage port
  logic        cpu_en_in;
  logic        cpu_en;
  logic [3:0]  cpu_mem_write_en;
  logic        cpu_mem_read_en;
  logic [31:0] cpu_mem_addr;
  logic [31:0] cpu_mem_write_data;
  logic [31:0] cpu_mem_read_data;

  // DMA / debug port
  logic        dma_req;
  logic [3:0]  dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;

  // Data memory port
  logic [3:0]  mem_write_en;
  logic        mem_read_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport slave (
    input  cpu_en_in,
    input  cpu_mem_write_en,
    input  cpu_mem_read_en,
    input  cpu_mem_addr,
    input  cpu_mem_write_data,
    output cpu_en,
    output cpu_mem_read_data,
    input  dma_req,
    input  dma_we,
    input  dma_addr,
    input  dma_wdata,
    output dma_gnt,
    output dma_rvalid,
    output dma_rdata,
    output mem_write_en,
    output mem_read_en,
    output mem_addr,
    output mem_write_data,
    input  mem_read_data
  );

  modport master (
    output cpu_en_in,
    output cpu_mem_write_en,
    output cpu_mem_read_en,
    output cpu_mem_addr,
    output cpu_mem_write_data,
    input  cpu_en,
    input  cpu_mem_read_data,
    output dma_req,
    output dma_we,
    output dma_addr,
    output dma_wdata,
    input  dma_gnt,
    input  dma_rvalid,
    input  dma_rdata,
    input  mem_write_en,
    input  mem_read_en,
    input  mem_addr,
    input  mem_write_data,
    output mem_read_data
  );

endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//   Shares the single-ported data memory between the CPU M-stage port and a
//   DMA/debug requester. The CPU normally has priority. A DMA request that
//   has been denied MAX_WAIT consecutive cycles is forced through. It then
//   keeps the port for a burst of up to BURST_LEN back-to-back grants.
//   Whenever the CPU needs memory in a cycle it loses, the pipeline is frozen
//   through cpu_en. The last CPU load result is replayed from a holding
//   register, so the M stage sees stable data while it is frozen.
//
// Parameters:
//   MAX_WAIT   denied DMA request cycles before a forced grant (1..255)
//   BURST_LEN  maximum consecutive DMA grants once forced (1..255)
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-low reset. While it is low, the grant, the CPU
//        enable, the memory enables and dma_rvalid are all held at 0.
//   bus  dmem_arbiter_if.slave. It carries the CPU, DMA and memory buses.
//
// Timing:
//   Grant, memory steering and cpu_en are combinational in the request cycle.
//   Writes commit at the grant edge. Read data returns exactly one cycle
//   after the grant.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    CPU_PRI   = 1'b0,
    DMA_BURST = 1'b1
  } state_e;

  localparam logic [7:0] MAX_WAIT_C  = 8'(MAX_WAIT);
  localparam logic [7:0] BURST_LEN_C = 8'(BURST_LEN);

  // Registered state
  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;
  logic        cpu_rd_pend_q, cpu_rd_pend_d;
  logic        dma_rd_pend_q, dma_rd_pend_d;
  logic [31:0] hold_q, hold_d;

  // Combinational decisions
  logic        cpu_req_s;
  logic        dma_win_s;
  logic [3:0]  mem_write_en_s;
  logic        mem_read_en_s;
  logic [31:0] mem_addr_s;
  logic [31:0] mem_write_data_s;

  // Request decode and arbitration decision; reset blocks every grant.
  always_comb begin
    cpu_req_s = bus.cpu_en_in & ((|bus.cpu_mem_write_en) | bus.cpu_mem_read_en);
    dma_win_s = 1'b0;
    if (rst && bus.dma_req &&
        (!cpu_req_s || (state_q == DMA_BURST) || (wait_cnt_q == MAX_WAIT_C))) begin
      dma_win_s = 1'b1;
    end else begin
      dma_win_s = 1'b0;
    end
  end

  // Memory port steering: the winner's fields, enables squashed in reset.
  always_comb begin
    mem_write_en_s   = 4'b0000;
    mem_read_en_s    = 1'b0;
    mem_addr_s       = 32'h0000_0000;
    mem_write_data_s = 32'h0000_0000;
    if (!rst) begin
      mem_write_en_s   = 4'b0000;
      mem_read_en_s    = 1'b0;
      mem_addr_s       = 32'h0000_0000;
      mem_write_data_s = 32'h0000_0000;
    end else if (dma_win_s) begin
      mem_write_en_s   = bus.dma_we;
      mem_read_en_s    = bus.dma_req & ~(|bus.dma_we);
      mem_addr_s       = bus.dma_addr;
      mem_write_data_s = bus.dma_wdata;
    end else if (bus.cpu_en_in) begin
      // Byte-lane order is passed through untouched (bit 3 = address byte 0).
      mem_write_en_s   = bus.cpu_mem_write_en;
      mem_read_en_s    = bus.cpu_mem_read_en;
      mem_addr_s       = bus.cpu_mem_addr;
      mem_write_data_s = bus.cpu_mem_write_data;
    end else begin
      mem_write_en_s   = 4'b0000;
      mem_read_en_s    = 1'b0;
      mem_addr_s       = 32'h0000_0000;
      mem_write_data_s = 32'h0000_0000;
    end
  end

  // DMA starvation counter: counts denied request cycles, saturating.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.dma_req || dma_win_s) begin
      wait_cnt_d = 8'd0;
    end else if (wait_cnt_q < MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Arbitration FSM next state and burst length tracking.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      CPU_PRI: begin
        // Only a forced grant (won against a live CPU request) opens a
        // burst. Grants won while the CPU is idle leave the state alone.
        if (cpu_req_s && dma_win_s) begin
          if (BURST_LEN_C == 8'd1) begin
            state_d     = CPU_PRI;
            burst_cnt_d = 8'd0;
          end else begin
            state_d     = DMA_BURST;
            burst_cnt_d = 8'd1;
          end
        end else begin
          state_d     = CPU_PRI;
          burst_cnt_d = burst_cnt_q;
        end
      end
      DMA_BURST: begin
        if (!bus.dma_req) begin
          state_d     = CPU_PRI;
          burst_cnt_d = 8'd0;
        end else if (dma_win_s) begin
          if ((burst_cnt_q + 8'd1) == BURST_LEN_C) begin
            state_d     = CPU_PRI;
            burst_cnt_d = 8'd0;
          end else begin
            state_d     = DMA_BURST;
            burst_cnt_d = burst_cnt_q + 8'd1;
          end
        end else begin
          state_d     = DMA_BURST;
          burst_cnt_d = burst_cnt_q;
        end
      end
      default: begin
        state_d     = CPU_PRI;
        burst_cnt_d = 8'd0;
      end
    endcase
  end

  // Read-return tracking and CPU load replay register next values.
  always_comb begin
    cpu_rd_pend_d = mem_read_en_s & ~dma_win_s;
    dma_rd_pend_d = dma_win_s & ~(|bus.dma_we);
    hold_d        = hold_q;
    if (cpu_rd_pend_q) begin
      hold_d = bus.mem_read_data;
    end else begin
      hold_d = hold_q;
    end
  end

  // Output drive: grants, CPU freeze, memory command and read returns.
  always_comb begin
    bus.dma_gnt        = dma_win_s;
    // Freeze only when the CPU actually needs the port it just lost.
    bus.cpu_en         = rst & bus.cpu_en_in & ~(cpu_req_s & dma_win_s);
    bus.mem_write_en   = mem_write_en_s;
    bus.mem_read_en    = mem_read_en_s;
    bus.mem_addr       = mem_addr_s;
    bus.mem_write_data = mem_write_data_s;
    bus.dma_rvalid     = rst & dma_rd_pend_q;
    bus.dma_rdata      = bus.mem_read_data;
    // Fresh load data on the return cycle, otherwise the held copy. This
    // stops DMA read data from leaking into a frozen M stage.
    if (cpu_rd_pend_q) begin
      bus.cpu_mem_read_data = bus.mem_read_data;
    end else begin
      bus.cpu_mem_read_data = hold_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= CPU_PRI;
      wait_cnt_q    <= 8'd0;
      burst_cnt_q   <= 8'd0;
      cpu_rd_pend_q <= 1'b0;
      dma_rd_pend_q <= 1'b0;
      hold_q        <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      burst_cnt_q   <= burst_cnt_d;
      cpu_rd_pend_q <= cpu_rd_pend_d;
      dma_rd_pend_q <= dma_rd_pend_d;
      hold_q        <= hold_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter. It includes a behavioural single-ported
// memory with one-cycle read latency. Expected DMA read data goes into a
// queue when the request is driven. A monitor pops the queue on each
// dma_rvalid.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int MW = 4;
  localparam int BL = 4;

  logic clk;
  logic rst;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .MAX_WAIT  (MW),
    .BURST_LEN (BL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int fails   = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] exp_dma_q [$];

  // Clock generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    if (we[3]) r[31:24] = wd[31:24];
    if (we[2]) r[23:16] = wd[23:16];
    if (we[1]) r[15:8]  = wd[15:8];
    if (we[0]) r[7:0]   = wd[7:0];
    return r;
  endfunction

  // Memory model: preloaded in reset, one-cycle read latency
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[10'h040] <= 32'hDEADBEEF;  // 0x100
      mem[10'h041] <= 32'h11223344;  // 0x104
      mem[10'h080] <= 32'hCAFEF00D;  // 0x200
      bus.mem_read_data <= 32'h0;
    end else begin
      if (bus.mem_write_en != 4'b0000)
        mem[bus.mem_addr[11:2]] <= merge(mem[bus.mem_addr[11:2]], bus.mem_write_data,
                                         bus.mem_write_en);
      if (bus.mem_read_en)
        bus.mem_read_data <= mem[bus.mem_addr[11:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic en_in, input logic [3:0] cwe, input logic cre,
                       input logic [31:0] caddr, input logic [31:0] cwd,
                       input logic dreq, input logic [3:0] dwe,
                       input logic [31:0] daddr, input logic [31:0] dwd);
    bus.cpu_en_in          = en_in;
    bus.cpu_mem_write_en   = cwe;
    bus.cpu_mem_read_en    = cre;
    bus.cpu_mem_addr       = caddr;
    bus.cpu_mem_write_data = cwd;
    bus.dma_req            = dreq;
    bus.dma_we             = dwe;
    bus.dma_addr           = daddr;
    bus.dma_wdata          = dwd;
  endtask

  task automatic idle();
    drive(1'b1, 4'h0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Scoreboard monitor: every dma_rvalid consumes one expected word
  always @(negedge clk) begin
    logic [31:0] e;
    #2;
    if (bus.dma_rvalid === 1'b1) begin
      if (exp_dma_q.size() == 0) begin
        chk("dma_rvalid_unexpected", 32'(bus.dma_rvalid), 32'd0);
      end else begin
        e = exp_dma_q.pop_front();
        chk("dma_rdata", bus.dma_rdata, e);
      end
    end
  end

  initial begin
    logic exp_g;
    logic dreq;
    int   n;

    // ---------------- reset forcing ----------------
    rst = 1'b0;
    drive(1'b1, 4'h0, 1'b1, 32'h100, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0);
    @(negedge clk); #1;
    chk("reset_cpu_en",       32'(bus.cpu_en),       32'd0);
    chk("reset_dma_gnt",      32'(bus.dma_gnt),      32'd0);
    chk("reset_mem_read_en",  32'(bus.mem_read_en),  32'd0);
    chk("reset_mem_write_en", 32'(bus.mem_write_en), 32'd0);
    chk("reset_dma_rvalid",   32'(bus.dma_rvalid),   32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle();

    // ---------------- CPU only ----------------
    @(negedge clk);
    drive(1'b1, 4'h0, 1'b1, 32'h100, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    chk("cpu_only_cpu_en",   32'(bus.cpu_en),      32'd1);
    chk("cpu_only_gnt",      32'(bus.dma_gnt),     32'd0);
    chk("cpu_only_mem_addr", bus.mem_addr,         32'h100);
    chk("cpu_only_rd_en",    32'(bus.mem_read_en), 32'd1);
    @(negedge clk);
    idle();
    #1;
    chk("cpu_only_rdata",  bus.cpu_mem_read_data, 32'hDEADBEEF);
    chk("cpu_only_cpu_en2", 32'(bus.cpu_en),      32'd1);
    @(negedge clk); #1;
    chk("cpu_only_hold",   bus.cpu_mem_read_data, 32'hDEADBEEF);

    // ---------------- DMA with CPU idle ----------------
    @(negedge clk);
    drive(1'b1, 4'h0, 1'b0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0);
    exp_dma_q.push_back(32'hCAFEF00D);
    #1;
    chk("dma_idle_gnt",      32'(bus.dma_gnt),     32'd1);
    chk("dma_idle_cpu_en",   32'(bus.cpu_en),      32'd1);
    chk("dma_idle_mem_addr", bus.mem_addr,         32'h200);
    chk("dma_idle_rd_en",    32'(bus.mem_read_en), 32'd1);
    @(negedge clk);
    idle();
    #1;
    chk("dma_idle_rvalid",  32'(bus.dma_rvalid), 32'd1);
    chk("dma_idle_cpu_en2", 32'(bus.cpu_en),     32'd1);

    // ---------------- starvation ----------------
    // First cycle is denied, which also shows the state stayed CPU_PRI.
    n = 0;
    for (int c = 1; c <= MW + BL + 2; c++) begin
      @(negedge clk);
      exp_g = (c > MW) && (c <= MW + BL);
      drive(1'b1, 4'h0, 1'b1, 32'h100, 32'h0, (n < BL), 4'hF,
            32'h400 + 32'(4 * n), 32'hA000_0000 + 32'(n));
      #1;
      chk("starve_gnt",      32'(bus.dma_gnt), 32'(exp_g));
      chk("starve_cpu_en",   32'(bus.cpu_en),  32'(!exp_g));
      chk("starve_mem_addr", bus.mem_addr, exp_g ? 32'h400 + 32'(4 * n) : 32'h100);
      if (exp_g) n++;
    end
    @(negedge clk);
    idle();
    #1;
    for (int i = 0; i < BL; i++)
      chk("starve_mem_write", mem[10'h100 + 10'(i)], 32'hA000_0000 + 32'(i));

    // ---------------- load replay ----------------
    for (int c = 1; c <= MW + BL + 1; c++) begin
      @(negedge clk);
      exp_g = (c > MW) && (c <= MW + BL);
      dreq  = (c <= MW + BL);
      drive(1'b1, 4'h0, 1'b1, 32'h104, 32'h0, dreq, 4'h0, 32'h200, 32'h0);
      if (exp_g) exp_dma_q.push_back(32'hCAFEF00D);
      #1;
      chk("replay_cpu_en", 32'(bus.cpu_en), 32'(!exp_g));
      if (c >= 2) chk("replay_cpu_rdata", bus.cpu_mem_read_data, 32'h11223344);
    end
    @(negedge clk);
    idle();

    // ---------------- early burst end ----------------
    // Request drops in cycle 7. Cycle 8 must be denied again.
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      exp_g = (c == MW + 1) || (c == MW + 2);
      dreq  = (c != MW + 3);
      drive(1'b1, 4'h0, 1'b1, 32'h100, 32'h0, dreq, 4'hF, 32'h500, 32'hB000_0000);
      #1;
      chk("early_gnt",    32'(bus.dma_gnt), 32'(exp_g));
      chk("early_cpu_en", 32'(bus.cpu_en),  32'(!exp_g));
    end
    @(negedge clk);
    idle();

    // ---------------- reset mid-burst ----------------
    for (int c = 1; c <= MW + 2; c++) begin
      @(negedge clk);
      if (c == MW + 2) rst = 1'b0;
      drive(1'b1, 4'h0, 1'b1, 32'h100, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0);
      #1;
      if (c <= MW + 1) begin
        chk("rstb_gnt", 32'(bus.dma_gnt), 32'(c == MW + 1));
      end else begin
        chk("rstb_gnt_in_reset",    32'(bus.dma_gnt),     32'd0);
        chk("rstb_cpu_en_in_reset", 32'(bus.cpu_en),      32'd0);
        chk("rstb_rvalid_in_reset", 32'(bus.dma_rvalid),  32'd0);
        chk("rstb_rd_en_in_reset",  32'(bus.mem_read_en), 32'd0);
      end
    end
    // After release: CPU_PRI with a cleared wait counter, so MW denials.
    for (int k = 1; k <= MW + 1; k++) begin
      @(negedge clk);
      rst = 1'b1;
      drive(1'b1, 4'h0, 1'b1, 32'h100, 32'h0, 1'b1, 4'hF, 32'h600, 32'h5A5A_5A5A);
      #1;
      if (k == 1) chk("post_rst_rvalid", 32'(bus.dma_rvalid), 32'd0);
      chk("post_rst_gnt",    32'(bus.dma_gnt), 32'(k == MW + 1));
      chk("post_rst_cpu_en", 32'(bus.cpu_en),  32'(k != MW + 1));
    end
    @(negedge clk);
    idle();
    @(negedge clk);
    @(negedge clk); #3;
    chk("post_rst_mem_write", mem[10'h180], 32'h5A5A_5A5A);
    chk("dma_queue_drained", 32'(exp_dma_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
